// File: rtl/cart_stream_loader.sv
// rtl/cart_stream_loader.sv - boot-time cartridge stream loader with GB header checksum gate
// Streams bytes into cartridge bank RAM and holds the DZCPU in reset until the image is accepted.
module cart_stream_loader #(
   parameter int ADDR_W     = 15,
   parameter int CART_BYTES = 32768,
   parameter bit STRICT     = 1'b1
) (
   input  logic              iClock,
   input  logic              iReset_n,
   input  logic              iStart,
   input  logic              iByteValid,
   input  logic [7:0]        iByte,
   output logic              oByteReady,
   output logic              oWe,
   output logic [ADDR_W-1:0] oAddr,
   output logic [7:0]        oData,
   output logic              oBusy,
   output logic              oDone,
   output logic              oChecksumOk,
   output logic              oCpuReset
);

   // One spare count bit so CART_BYTES == 2**ADDR_W still compares cleanly.
   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] CountLast = CW'(CART_BYTES - 1);
   localparam logic [CW-1:0] SumFirst  = CW'(16'h134);
   localparam logic [CW-1:0] SumLast   = CW'(16'h14C);
   localparam logic [CW-1:0] StoredAt  = CW'(16'h14D);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLoad  = 3'd1;
   localparam logic [2:0] StCheck = 3'd2;
   localparam logic [2:0] StDone  = 3'd3;
   localparam logic [2:0] StError = 3'd4;

   logic [2:0]    state;
   logic [CW-1:0] count;
   logic [7:0]    sum;
   logic [7:0]    stored;
   logic          accept;
   logic          checksumMatch;

   assign oByteReady    = (state == StLoad);
   assign oBusy         = (state == StLoad) || (state == StCheck);
   assign oDone         = (state == StDone);
   assign accept        = iByteValid & oByteReady;
   assign checksumMatch = (sum == stored);

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         state       <= StIdle;
         count       <= '0;
         sum         <= '0;
         stored      <= '0;
         oWe         <= 1'b0;
         oAddr       <= '0;
         oData       <= '0;
         oChecksumOk <= 1'b0;
         oCpuReset   <= 1'b1;
      end else begin
         // RAM never stalls, so every accepted byte is written on the following cycle.
         oWe <= accept;
         if (accept) begin
            oAddr <= count[ADDR_W-1:0];
            oData <= iByte;
         end

         case (state)
            StIdle, StDone, StError: begin
               if (iStart) begin
                  state       <= StLoad;
                  count       <= '0;
                  sum         <= '0;
                  stored      <= '0;
                  oCpuReset   <= 1'b1;
                  oChecksumOk <= 1'b0;
               end
            end
            StLoad: begin
               if (accept) begin
                  count <= count + CW'(1);
                  if (count >= SumFirst && count <= SumLast)
                     sum <= sum - iByte - 8'd1;
                  if (count == StoredAt)
                     stored <= iByte;
                  if (count == CountLast)
                     state <= StCheck;
               end
            end
            StCheck: begin
               oChecksumOk <= checksumMatch;
               if (checksumMatch || !STRICT) begin
                  state     <= StDone;
                  oCpuReset <= 1'b0;
               end else begin
                  state <= StError;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cart_stream_loader.sv
// tb/tb_cart_stream_loader.sv - scoreboard bench for cart_stream_loader (strict and lenient instances)
module tb_cart_stream_loader;

   localparam int N = 'h150;

   logic       iClock = 1'b0;
   logic       iReset_n;
   logic       iStart;
   logic       iByteValid;
   logic [7:0] iByte;

   logic        readyA, weA, busyA, doneA, okA, cpuA;
   logic [14:0] addrA;
   logic [7:0]  dataA;
   logic        readyB, weB, busyB, doneB, okB, cpuB;
   logic [14:0] addrB;
   logic [7:0]  dataB;

   always #5 iClock = ~iClock;

   cart_stream_loader #(.ADDR_W(15), .CART_BYTES(N), .STRICT(1'b1)) dutA (
      .iClock(iClock), .iReset_n(iReset_n), .iStart(iStart), .iByteValid(iByteValid), .iByte(iByte),
      .oByteReady(readyA), .oWe(weA), .oAddr(addrA), .oData(dataA), .oBusy(busyA), .oDone(doneA),
      .oChecksumOk(okA), .oCpuReset(cpuA));

   cart_stream_loader #(.ADDR_W(15), .CART_BYTES(N), .STRICT(1'b0)) dutB (
      .iClock(iClock), .iReset_n(iReset_n), .iStart(iStart), .iByteValid(iByteValid), .iByte(iByte),
      .oByteReady(readyB), .oWe(weB), .oAddr(addrB), .oData(dataB), .oBusy(busyB), .oDone(doneB),
      .oChecksumOk(okB), .oCpuReset(cpuB));

   typedef struct packed {
      logic [31:0] cyc;
      logic [14:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t        qa[$];
   wr_t        qb[$];
   logic [7:0] img [0:N-1];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         n;

   always @(posedge iClock) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Expected write: byte i lands at address i, exactly one cycle after its accept.
   wr_t ea, eb;
   always @(negedge iClock) begin
      if (weA) begin
         if (qa.size() == 0) chk("weA_unexpected", 1, 0);
         else begin
            ea = qa.pop_front();
            chk("wrA_cycle", cyc, int'(ea.cyc));
            chk("wrA_addr", int'(addrA), int'(ea.addr));
            chk("wrA_data", int'(dataA), int'(ea.data));
         end
      end
   end
   always @(negedge iClock) begin
      if (weB) begin
         if (qb.size() == 0) chk("weB_unexpected", 1, 0);
         else begin
            eb = qb.pop_front();
            chk("wrB_cycle", cyc, int'(eb.cyc));
            chk("wrB_addr", int'(addrB), int'(eb.addr));
            chk("wrB_data", int'(dataB), int'(eb.data));
         end
      end
   end

   function automatic int header_total();
      int total = 0;
      for (int a = 'h134; a <= 'h14C; a++) total += int'(img[a]) + 1;
      return total;
   endfunction

   // Header is good when stored byte plus all (byte+1) terms sums to 0 mod 256.
   function automatic bit model_ok();
      return ((header_total() + int'(img['h14D])) % 256) == 0;
   endfunction

   function automatic void fix_header();
      img['h14D] = 8'((256 - (header_total() % 256)) % 256);
   endfunction

   task automatic fill_t1();
      for (int a = 0; a < N; a++) img[a] = 8'h00;
      img['h134] = 8'h54; img['h135] = 8'h45; img['h136] = 8'h54; img['h137] = 8'h52;
      img['h14D] = 8'hA8;
   endtask

   task automatic fill_random();
      for (int a = 0; a < N; a++) img[a] = 8'($urandom);
      fix_header();
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_readyA"}, readyA, 0); chk({tag, "_weA"}, weA, 0);
      chk({tag, "_addrA"}, int'(addrA), 0); chk({tag, "_dataA"}, int'(dataA), 0);
      chk({tag, "_busyA"}, busyA, 0); chk({tag, "_doneA"}, doneA, 0);
      chk({tag, "_okA"}, okA, 0); chk({tag, "_cpuA"}, cpuA, 1);
      chk({tag, "_readyB"}, readyB, 0); chk({tag, "_cpuB"}, cpuB, 1);
   endtask

   // Called on a negedge; returns on the negedge after the last accepted byte.
   task automatic run_load(input int gap_pct, input int stop_after, input int restart_at,
                           output int accepted);
      int i = 0;
      int budget = 0;
      iStart = 1'b1;
      @(negedge iClock);
      iStart = 1'b0;
      while (i < stop_after && budget < 4000) begin
         budget++;
         iStart = (i == restart_at);
         if ($urandom_range(99) < gap_pct) begin
            iByteValid = 1'b0;
            iByte = 8'($urandom);
         end else begin
            iByteValid = 1'b1;
            iByte = img[i];
            chk("load_readyA", readyA, 1);
            chk("load_readyB", readyB, 1);
            qa.push_back(wr_t'{cyc + 1, 15'(i), img[i]});
            qb.push_back(wr_t'{cyc + 1, 15'(i), img[i]});
            i++;
         end
         @(negedge iClock);
      end
      iByteValid = 1'b0;
      iStart = 1'b0;
      if (budget >= 4000) chk("load_timeout", 0, 1);
      accepted = i;
   endtask

   task automatic finish_checks(input string tag);
      bit ok;
      ok = model_ok();
      chk({tag, "_check_busyA"}, busyA, 1);
      chk({tag, "_check_doneA"}, doneA, 0);
      chk({tag, "_check_cpuA"}, cpuA, 1);
      @(negedge iClock);
      chk({tag, "_busyA"}, busyA, 0);
      chk({tag, "_doneA"}, doneA, int'(ok));
      chk({tag, "_okA"}, okA, int'(ok));
      chk({tag, "_cpuA"}, cpuA, int'(!ok));
      chk({tag, "_doneB"}, doneB, 1);
      chk({tag, "_okB"}, okB, int'(ok));
      chk({tag, "_cpuB"}, cpuB, 0);
      chk({tag, "_readyA_after"}, readyA, 0);
      @(negedge iClock);
      chk({tag, "_pendingA"}, qa.size(), 0);
      chk({tag, "_pendingB"}, qb.size(), 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   initial begin
      iReset_n = 1'b0; iStart = 1'b0; iByteValid = 1'b0; iByte = 8'h00;
      repeat (3) @(negedge iClock);
      check_reset_vals("reset");
      iReset_n = 1'b1;
      @(negedge iClock);
      check_reset_vals("idle");

      fill_t1();
      run_load(0, N, -1, n);
      finish_checks("t1");

      run_load(50, N, -1, n);
      finish_checks("t2");

      img['h14D] = 8'hA7;
      run_load(30, N, -1, n);
      finish_checks("t3_bad");
      img['h14D] = 8'hA8;
      run_load(30, N, -1, n);
      finish_checks("t3_good");

      img['h14D] = 8'h00;
      run_load(20, N, -1, n);
      finish_checks("t4");

      fill_random();
      run_load(40, N, 200, n);
      finish_checks("t6");

      fill_random();
      run_load(20, 100, -1, n);
      #1 iReset_n = 1'b0;
      #1 check_reset_vals("t5_abort");
      qa.delete();
      qb.delete();
      @(negedge iClock);
      iReset_n = 1'b1;
      iByteValid = 1'b1;
      iByte = 8'h5A;
      repeat (5) begin
         @(negedge iClock);
         chk("t5_readyA", readyA, 0);
         chk("t5_busyA", busyA, 0);
      end
      iByteValid = 1'b0;
      img[7] = img[7] ^ 8'h01;
      run_load(25, N, -1, n);
      finish_checks("t5_reload");

      fill_random();
      img['h140] = img['h140] + 8'd1;
      run_load(35, N, -1, n);
      finish_checks("rand_bad");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
